// File: rtl/rv32_decode_pkg.sv
// Shared RV32I decode definitions: major opcodes, immediate-format codes and
// the decoded operand-B record carried through the skid buffer.
package rv32_decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_R     = 3'd0;
    localparam logic [2:0] IMM_I     = 3'd1;
    localparam logic [2:0] IMM_S     = 3'd2;
    localparam logic [2:0] IMM_B     = 3'd3;
    localparam logic [2:0] IMM_U     = 3'd4;
    localparam logic [2:0] IMM_J     = 3'd5;
    localparam logic [2:0] IMM_SHAMT = 3'd6;
    localparam logic [2:0] IMM_NONE  = 3'd7;

    // funct3 values of the OP-IMM shift instructions (SLLI, SRLI/SRAI)
    localparam logic [2:0] F3_SLLI      = 3'b001;
    localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

    typedef struct packed {
        logic        alusrc;
        logic [31:0] imm_val;
        logic [2:0]  imm_type;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decoder: classifies the instruction format,
// builds the extended immediate and picks the ALU operand-B source.
module imm_decode
    import rv32_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic        alusrc,
    output logic [31:0] imm_val,
    output logic [2:0]  imm_type,
    output logic        illegal
);

    // Format classification and immediate assembly by major opcode
    always_comb begin
        alusrc   = 1'b0;
        imm_val  = 32'd0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (instr[6:0])
            OPC_OPIMM: begin
                alusrc = 1'b1;
                if ((instr[14:12] == F3_SLLI) || (instr[14:12] == F3_SRLI_SRAI)) begin
                    // Shift amount is unsigned; instr[30] only selects SRA vs SRL
                    imm_type = IMM_SHAMT;
                    imm_val  = {27'd0, instr[24:20]};
                end else begin
                    imm_type = IMM_I;
                    imm_val  = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                alusrc   = 1'b1;
                imm_type = IMM_I;
                imm_val  = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                alusrc   = 1'b1;
                imm_type = IMM_S;
                imm_val  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                // Branch compare needs rs2, so operand B stays on register data
                alusrc   = 1'b0;
                imm_type = IMM_B;
                imm_val  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                alusrc   = 1'b1;
                imm_type = IMM_U;
                imm_val  = {instr[31:12], 12'd0};
            end
            OPC_JAL: begin
                alusrc   = 1'b1;
                imm_type = IMM_J;
                imm_val  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP: begin
                alusrc   = 1'b0;
                imm_type = IMM_R;
                imm_val  = 32'd0;
            end
            default: begin
                alusrc   = 1'b0;
                imm_type = IMM_NONE;
                imm_val  = 32'd0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_operand_stage.sv
// Registered operand-B producer: decodes incoming instruction words and
// presents alusrc/imm results through a 2-entry skid buffer (main + skid).
module imm_operand_stage
    import rv32_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            alusrc,
    output logic [XLEN-1:0] imm_val,
    output logic [2:0]      imm_type,
    output logic            illegal
);

    logic        dec_alusrc_s;
    logic [31:0] dec_imm_val_s;
    logic [2:0]  dec_imm_type_s;
    logic        dec_illegal_s;
    dec_t        dec_s;

    logic        main_valid_r;
    logic        skid_valid_r;
    logic        in_ready_r;
    dec_t        main_r;
    dec_t        skid_r;

    logic        main_valid_s;
    logic        skid_valid_s;
    dec_t        main_s;
    dec_t        skid_s;
    logic        in_fire_s;
    logic        out_fire_s;

    imm_decode u_imm_decode (
        .instr    (in_instr[31:0]),
        .alusrc   (dec_alusrc_s),
        .imm_val  (dec_imm_val_s),
        .imm_type (dec_imm_type_s),
        .illegal  (dec_illegal_s)
    );

    assign dec_s      = '{alusrc: dec_alusrc_s, imm_val: dec_imm_val_s,
                          imm_type: dec_imm_type_s, illegal: dec_illegal_s};
    assign in_fire_s  = in_valid && in_ready_r;
    assign out_fire_s = main_valid_r && out_ready;

    // Buffer steering: refill main from skid first, then from the input
    always_comb begin
        main_valid_s = main_valid_r;
        skid_valid_s = skid_valid_r;
        main_s       = main_r;
        skid_s       = skid_r;
        if (flush) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
        end else if (skid_valid_r) begin
            // in_ready is low while skid holds a word, so no input can arrive
            if (out_fire_s) begin
                main_s       = skid_r;
                skid_valid_s = 1'b0;
            end else begin
                main_s = main_r;
            end
        end else if (in_fire_s) begin
            if (!main_valid_r || out_fire_s) begin
                main_s       = dec_s;
                main_valid_s = 1'b1;
            end else begin
                skid_s       = dec_s;
                skid_valid_s = 1'b1;
            end
        end else if (out_fire_s) begin
            main_valid_s = 1'b0;
        end else begin
            main_valid_s = main_valid_r;
        end
    end

    // State registers; in_ready is registered from the next skid occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            main_r       <= '0;
            skid_r       <= '0;
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= !skid_valid_s;
            main_r       <= main_s;
            skid_r       <= skid_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign alusrc    = main_r.alusrc;
    assign imm_val   = main_r.imm_val;
    assign imm_type  = main_r.imm_type;
    assign illegal   = main_r.illegal;

endmodule

// File: tb/tb_imm_operand_stage.sv
// Directed self-checking bench for imm_operand_stage.
module tb_imm_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        alusrc;
    logic [31:0] imm_val;
    logic [2:0]  imm_type;
    logic        illegal;

    int checks;
    int failures;

    imm_operand_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alusrc    (alusrc),
        .imm_val   (imm_val),
        .imm_type  (imm_type),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; flush = 1'b0; out_ready = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if ({alusrc, imm_val, imm_type, illegal} !== 37'd0) begin
            failures++; $display("FAIL reset_payload alusrc=%b imm=%h type=%0d ill=%b exp all 0", alusrc, imm_val, imm_type, illegal);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_decode_back_to_back();
        logic [31:0] t_instr [12];
        logic [31:0] t_imm   [12];
        logic [2:0]  t_type  [12];
        logic        t_src   [12];
        logic        t_ill   [12];
        t_instr[0]  = 32'hFFF00093; t_imm[0]  = 32'hFFFFFFFF; t_type[0]  = 3'd1; t_src[0]  = 1'b1; t_ill[0]  = 1'b0;
        t_instr[1]  = 32'hFE112E23; t_imm[1]  = 32'hFFFFFFFC; t_type[1]  = 3'd2; t_src[1]  = 1'b1; t_ill[1]  = 1'b0;
        t_instr[2]  = 32'h123452B7; t_imm[2]  = 32'h12345000; t_type[2]  = 3'd4; t_src[2]  = 1'b1; t_ill[2]  = 1'b0;
        t_instr[3]  = 32'h40515293; t_imm[3]  = 32'h00000005; t_type[3]  = 3'd6; t_src[3]  = 1'b1; t_ill[3]  = 1'b0;
        t_instr[4]  = 32'h0000007F; t_imm[4]  = 32'h00000000; t_type[4]  = 3'd7; t_src[4]  = 1'b0; t_ill[4]  = 1'b1;
        t_instr[5]  = 32'hFE000EE3; t_imm[5]  = 32'hFFFFFFFC; t_type[5]  = 3'd3; t_src[5]  = 1'b0; t_ill[5]  = 1'b0;
        t_instr[6]  = 32'h0080006F; t_imm[6]  = 32'h00000008; t_type[6]  = 3'd5; t_src[6]  = 1'b1; t_ill[6]  = 1'b0;
        t_instr[7]  = 32'h002081B3; t_imm[7]  = 32'h00000000; t_type[7]  = 3'd0; t_src[7]  = 1'b0; t_ill[7]  = 1'b0;
        t_instr[8]  = 32'h01012083; t_imm[8]  = 32'h00000010; t_type[8]  = 3'd1; t_src[8]  = 1'b1; t_ill[8]  = 1'b0;
        t_instr[9]  = 32'hFFC08067; t_imm[9]  = 32'hFFFFFFFC; t_type[9]  = 3'd1; t_src[9]  = 1'b1; t_ill[9]  = 1'b0;
        t_instr[10] = 32'h00001097; t_imm[10] = 32'h00001000; t_type[10] = 3'd4; t_src[10] = 1'b1; t_ill[10] = 1'b0;
        t_instr[11] = 32'h01F09093; t_imm[11] = 32'h0000001F; t_type[11] = 3'd6; t_src[11] = 1'b1; t_ill[11] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_instr = t_instr[i];
            tick();
            checks++;
            if ({out_valid, in_ready} !== 2'b11) begin
                failures++; $display("FAIL dec%0d_handshake out_valid=%b in_ready=%b exp 1 1", i, out_valid, in_ready);
            end
            checks++;
            if (imm_val !== t_imm[i]) begin
                failures++; $display("FAIL dec%0d_imm instr=%h got=%h exp=%h", i, t_instr[i], imm_val, t_imm[i]);
            end
            checks++;
            if ({alusrc, imm_type, illegal} !== {t_src[i], t_type[i], t_ill[i]}) begin
                failures++; $display("FAIL dec%0d_fields instr=%h alusrc=%b type=%0d ill=%b exp %b %0d %b",
                                     i, t_instr[i], alusrc, imm_type, illegal, t_src[i], t_type[i], t_ill[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL dec_drain out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        tick();
        checks++;
        if ({out_valid, in_ready, imm_val} !== {2'b11, 32'hFFFFFFFF}) begin
            failures++; $display("FAIL stall_first out_valid=%b in_ready=%b imm=%h exp 1 1 ffffffff", out_valid, in_ready, imm_val);
        end
        in_instr = 32'h01012083;
        tick();
        checks++;
        if ({out_valid, in_ready, imm_val} !== {2'b10, 32'hFFFFFFFF}) begin
            failures++; $display("FAIL stall_second out_valid=%b in_ready=%b imm=%h exp 1 0 ffffffff", out_valid, in_ready, imm_val);
        end
        in_instr = 32'h0080006F;
        tick();
        checks++;
        if ({out_valid, in_ready, imm_val, imm_type} !== {2'b10, 32'hFFFFFFFF, 3'd1}) begin
            failures++; $display("FAIL stall_hold out_valid=%b in_ready=%b imm=%h type=%0d exp 1 0 ffffffff 1",
                                 out_valid, in_ready, imm_val, imm_type);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready, imm_val, imm_type} !== {2'b11, 32'h00000010, 3'd1}) begin
            failures++; $display("FAIL stall_rel1 out_valid=%b in_ready=%b imm=%h type=%0d exp 1 1 00000010 1",
                                 out_valid, in_ready, imm_val, imm_type);
        end
        tick();
        checks++;
        if ({out_valid, imm_val, imm_type} !== {1'b1, 32'h00000008, 3'd5}) begin
            failures++; $display("FAIL stall_rel2 out_valid=%b imm=%h type=%0d exp 1 00000008 5", out_valid, imm_val, imm_type);
        end
        in_instr = 32'h002081B3;
        tick();
        checks++;
        if ({out_valid, imm_val, imm_type, alusrc} !== {1'b1, 32'h00000000, 3'd0, 1'b0}) begin
            failures++; $display("FAIL stall_rel3 out_valid=%b imm=%h type=%0d alusrc=%b exp 1 0 0 0", out_valid, imm_val, imm_type, alusrc);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_empty out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        tick();
        in_instr  = 32'h01012083;
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            failures++; $display("FAIL flush_full out_valid=%b in_ready=%b exp 1 0", out_valid, in_ready);
        end
        flush    = 1'b1;
        in_instr = 32'h0080006F;
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++; $display("FAIL flush_clear out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost out_valid=%b imm=%h exp valid 0", out_valid, imm_val); end
        in_valid = 1'b1;
        in_instr = 32'h123452B7;
        tick();
        checks++;
        if ({out_valid, imm_val} !== {1'b1, 32'h12345000}) begin
            failures++; $display("FAIL flush_resume out_valid=%b imm=%h exp 1 12345000", out_valid, imm_val);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drain out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0000007F;
        tick();
        in_instr  = 32'hFE112E23;
        tick();
        checks++;
        if ({out_valid, illegal, in_ready} !== 3'b110) begin
            failures++; $display("FAIL arst_pre out_valid=%b illegal=%b in_ready=%b exp 1 1 0", out_valid, illegal, in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++; $display("FAIL arst_async out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
        checks++;
        if ({alusrc, imm_val, imm_type, illegal} !== 37'd0) begin
            failures++; $display("FAIL arst_payload alusrc=%b imm=%h type=%0d ill=%b exp all 0", alusrc, imm_val, imm_type, illegal);
        end
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h40515293;
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, imm_val, imm_type} !== {1'b1, 32'h00000005, 3'd6}) begin
            failures++; $display("FAIL arst_after out_valid=%b imm=%h type=%0d exp 1 00000005 6", out_valid, imm_val, imm_type);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_drain out_valid=%b exp=0 (stale skid word)", out_valid); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_decode_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_operand_stage.md
# imm_operand_stage

Registered producer for the ALU operand-B select interface (`alusrc`, `imm_val`), the decode-side counterpart to the ALU source mux. The block accepts raw RV32I instruction words over a valid/ready handshake. It classifies each word by format, builds the sign- or zero-extended immediate, and derives `alusrc`. It presents the result to the execute stage through a 2-entry skid buffer, so throughput is one instruction per cycle under backpressure.

## Interface
Parameters:
- XLEN, 32, datapath and instruction width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction word on `in_instr` is valid.
- in_ready  out  1  block can accept; registered.
- in_instr  in  32  RV32I instruction word.
- flush  in  1  synchronous; discards all buffered entries.
- out_valid  out  1  `alusrc`/`imm_val`/`imm_type`/`illegal` are valid.
- out_ready  in  1  execute stage consumes this cycle.
- alusrc  out  1  1 selects `imm_val` as ALU operand B; 0 selects register data.
- imm_val  out  32  decoded immediate.
- imm_type  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, NONE=7.
- illegal  out  1  opcode is not RV32I.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Decode is by opcode `in_instr[6:0]`:
  - 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR): I-type; imm = sext(instr[31:20]); alusrc=1.
  - OP-IMM with funct3 001 or 101: SHAMT; imm = {27'b0, instr[24:20]}; alusrc=1.
  - 0100011: S-type; imm = sext({instr[31:25], instr[11:7]}); alusrc=1.
  - 1100011: B-type; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); alusrc=0, because the compare uses registers.
  - 0110111, 0010111: U-type; imm = {instr[31:12], 12'b0}; alusrc=1.
  - 1101111: J-type; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}); alusrc=1.
  - 0110011: R-type; imm=0; alusrc=0.
  - Any other opcode: NONE; illegal=1, imm=0, alusrc=0. The word still passes through in order.
- Buffering uses a main register (drives outputs) and a skid register.
  - Input accepted while main is empty, or main is draining this cycle: the word loads into main.
  - Input accepted while main is full and not draining: the word goes to skid.
  - When main drains and skid is full: skid moves to main, and skid clears.
  - `in_ready` next = !skid_valid_next.
- While `out_valid && !out_ready`, all output payload holds stable.
- `flush` clears both valids next edge. An input word presented in the same cycle as `flush` is dropped. `in_ready` is 1 the cycle after a flush.
- Reset clears everything. On `rst` assert, immediately: `out_valid`=0, payload outputs=0, `illegal`=0, `imm_type`=0, `in_ready`=1. Reset asserted mid-transfer loses all buffered words.

## Timing
- Latency is 1 cycle: a word accepted at edge N is on the outputs with `out_valid`=1 after edge N.
- Sustained throughput is 1 word/cycle while `out_ready`=1.
- With `out_ready` held low, at most 2 words are accepted. `in_ready` drops the cycle after the second accept.
- Ordering is strict FIFO. The skid entry is never presented ahead of the main entry.
- There are no combinational paths from `out_ready` to `in_ready`, or from `in_instr` to any output.

## Structure
- Shared package `rv32_decode_pkg` holds:
  - opcode localparams: OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR;
  - the `imm_type` encodings IMM_R … IMM_NONE.
- One combinational sub-module `imm_decode`: takes `instr[31:0]`, produces `alusrc`, `imm_val`, `imm_type` and `illegal`. It instantiates once on the input side, and both registers store decoded results.

## Test plan
- 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, imm_val=0xFFFFFFFF, alusrc=1, imm_type=1.
- 0xFE112E23 (sw x1,-4(x2)) then 0x123452B7 (lui x5,0x12345) back-to-back → imm_val 0xFFFFFFFC, then 0x12345000; both alusrc=1 on consecutive cycles.
- out_ready=0 for 3 cycles with 4 words offered → first 2 accepted, in_ready=0 after the second accept. On release, words emerge in order with payload stable during the stall.
- Both entries full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed and offered words never appear.
- 0x0000007F → illegal=1, imm_val=0, alusrc=0, imm_type=7. 0x40515293 (srai x5,x2,5) → imm_val=0x00000005, imm_type=6.
- rst asserted asynchronously mid-stall → out_valid falls without a clock edge, in_ready=1. After release, the first new word decodes with 1-cycle latency.
